// File: rtl/spi_regfile.sv
// SPI mode-0 slave register file: write frames commit on cs_n rise and read
// frames shift register contents out on sdo. All logic runs on clk.
module spi_regfile #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       cs_n,
  input  logic                       sdi,
  output logic                       sdo,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CMD_W   = 1 + ADDR_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam int SH_W    = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam logic [ADDR_W:0] NREG_L = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_DATA_WR, S_DATA_RD, S_CHECK} state_t;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < NREG_L;
  endfunction

  state_t              state_q, state_d;
  logic [2:0]          sclk_sync_q, cs_sync_q;
  logic [1:0]          sdi_sync_q;
  logic [CNT_W-1:0]    cnt_q, cnt_inc;
  logic [SH_W-1:0]     shift_q;
  logic [DATA_W-1:0]   rd_shift_q, rd_word;
  logic                rw_q;
  logic [ADDR_W-1:0]   addr_q, wr_addr_q;
  logic                wr_strobe_q, frame_err_q;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [CMD_W-1:0]    cmd_word;
  logic                sclk_rise, sclk_fall, cs_rise, cs_fall, sdi_s;
  logic                clear, shift_en, cnt_en, latch_cmd, load_rd, shift_rd;
  logic                check, commit, err;

  // cs_n sync flops reset low so a frame already in progress at reset
  // release produces no falling edge until cs_n has gone high first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], sclk};
      cs_sync_q   <= {cs_sync_q[1:0], cs_n};
    end
  end

  always_ff @(posedge clk) sdi_sync_q <= {sdi_sync_q[0], sdi};

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
  assign sdi_s     = sdi_sync_q[1];
  assign cmd_word  = {shift_q[ADDR_W-1:0], sdi_s};
  assign cnt_inc   = (cnt_q == CNT_W'(FRAME_W + 1)) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (cmd_word[ADDR_W-1:0] == ADDR_W'(k)) rd_word = regs_q[k];
  end

  always_comb begin
    state_d   = state_q;
    clear     = 1'b0;
    shift_en  = 1'b0;
    cnt_en    = 1'b0;
    latch_cmd = 1'b0;
    load_rd   = 1'b0;
    shift_rd  = 1'b0;
    check     = 1'b0;
    case (state_q)
      S_IDLE: begin
        clear = 1'b1;
        if (cs_fall) state_d = S_CMD;
      end
      S_CMD: begin
        if (cs_rise) state_d = S_CHECK;
        else if (sclk_rise) begin
          shift_en = 1'b1;
          cnt_en   = 1'b1;
          if (cnt_q == CNT_W'(CMD_W - 1)) begin
            latch_cmd = 1'b1;
            load_rd   = ~cmd_word[CMD_W-1];
            state_d   = cmd_word[CMD_W-1] ? S_DATA_WR : S_DATA_RD;
          end
        end
      end
      S_DATA_WR: begin
        if (cs_rise) state_d = S_CHECK;
        else if (sclk_rise) begin
          shift_en = 1'b1;
          cnt_en   = 1'b1;
        end
      end
      S_DATA_RD: begin
        // The fall right after the last address bit must keep the MSB in place.
        if (cs_rise) state_d = S_CHECK;
        else begin
          cnt_en   = sclk_rise;
          shift_rd = sclk_fall && (cnt_q > CNT_W'(CMD_W));
        end
      end
      S_CHECK: begin
        check   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign commit = check && rw_q && (cnt_q == CNT_W'(FRAME_W)) && addr_ok(addr_q);
  assign err    = check && ((cnt_q != CNT_W'(FRAME_W)) || !addr_ok(addr_q));

  always_ff @(posedge clk) begin
    if (clear) begin
      shift_q <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      if (shift_en) shift_q <= SH_W'({shift_q, sdi_s});
      if (latch_cmd) begin
        rw_q   <= cmd_word[CMD_W-1];
        addr_q <= cmd_word[ADDR_W-1:0];
      end
    end
    if (load_rd)       rd_shift_q <= rd_word;
    else if (shift_rd) rd_shift_q <= rd_shift_q << 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      wr_addr_q   <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      wr_strobe_q <= commit;
      frame_err_q <= err;
      if (clear)       cnt_q <= '0;
      else if (cnt_en) cnt_q <= cnt_inc;
      if (commit) wr_addr_q <= addr_q;
      for (int k = 0; k < NUM_REGS; k++)
        if (commit && addr_q == ADDR_W'(k)) regs_q[k] <= shift_q[DATA_W-1:0];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign sdo       = (state_q == S_DATA_RD) & rd_shift_q[DATA_W-1];
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_regfile.sv
// Directed bench for spi_regfile: default build plus a NUM_REGS=5/DATA_W=16/ADDR_W=3 build.
module tb_spi_regfile;

  localparam int HALF = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        sdi = 1'b0;
  logic        cs0_n = 1'b1, cs1_n = 1'b1;
  logic        sdo0, sdo1;
  logic [63:0] regs0;
  logic [79:0] regs1;
  logic        wr_strobe0, wr_strobe1, frame_err0, frame_err1;
  logic [6:0]  wr_addr0;
  logic [2:0]  wr_addr1;

  int n_checks = 0;
  int n_errors = 0;
  int stb0 = 0, err0 = 0, stb1 = 0, err1 = 0;

  always #5 clk = ~clk;

  spi_regfile dut0 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs0_n), .sdi(sdi), .sdo(sdo0),
    .regs(regs0), .wr_strobe(wr_strobe0), .wr_addr(wr_addr0), .frame_err(frame_err0)
  );

  spi_regfile #(.NUM_REGS(5), .DATA_W(16), .ADDR_W(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs1_n), .sdi(sdi), .sdo(sdo1),
    .regs(regs1), .wr_strobe(wr_strobe1), .wr_addr(wr_addr1), .frame_err(frame_err1)
  );

  // Count high cycles so a stretched pulse shows up as an extra event.
  always @(posedge clk) begin
    if (wr_strobe0) stb0 <= stb0 + 1;
    if (frame_err0) err0 <= err0 + 1;
    if (wr_strobe1) stb1 <= stb1 + 1;
    if (frame_err1) err1 <= err1 + 1;
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cs_low(input int dut);
    if (dut == 0) cs0_n = 1'b0; else cs1_n = 1'b0;
    #HALF;
  endtask

  task automatic cs_high(input int dut, input int gap);
    if (dut == 0) cs0_n = 1'b1; else cs1_n = 1'b1;
    #gap;
  endtask

  task automatic spi_bits(input int dut, input logic [31:0] val, input int n,
                          output logic [31:0] rd);
    rd = '0;
    for (int i = n - 1; i >= 0; i--) begin
      sdi = val[i];
      #HALF;
      sclk = 1'b1;
      rd = {rd[30:0], (dut == 0) ? sdo0 : sdo1};
      #HALF;
      sclk = 1'b0;
    end
    #HALF;
  endtask

  task automatic frame(input int dut, input logic [31:0] val, input int n, input int gap,
                       output logic [31:0] rd);
    cs_low(dut);
    spi_bits(dut, val, n, rd);
    cs_high(dut, gap);
  endtask

  initial begin
    logic [31:0] rd;
    int s, e;

    #30 rst_n = 1'b1;
    #40;
    chk("rst_regs", regs0, 0);
    chk("rst_wr_addr", wr_addr0, 0);
    chk("rst_sdo", sdo0, 0);
    chk("rst_strobe", wr_strobe0, 0);
    chk("rst_frame_err", frame_err0, 0);

    // write addr 3 = 0xA5
    s = stb0; e = err0;
    frame(0, 32'h83A5, 16, 100, rd);
    chk("wr3_regs", regs0, 64'h0000_0000_A500_0000);
    chk("wr3_wr_addr", wr_addr0, 3);
    chk("wr3_strobes", stb0 - s, 1);
    chk("wr3_errs", err0 - e, 0);

    // read addr 3
    s = stb0; e = err0;
    frame(0, 32'h0300, 16, 100, rd);
    chk("rd3_data", rd[15:0], 16'h00A5);
    chk("rd3_regs", regs0, 64'h0000_0000_A500_0000);
    chk("rd3_errs", err0 - e, 0);
    chk("rd3_strobes", stb0 - s, 0);
    chk("rd3_sdo_idle", sdo0, 0);

    // write addr 8 (out of range)
    s = stb0; e = err0;
    frame(0, 32'h8855, 16, 100, rd);
    chk("wr8_regs", regs0, 64'h0000_0000_A500_0000);
    chk("wr8_errs", err0 - e, 1);
    chk("wr8_strobes", stb0 - s, 0);
    chk("wr8_wr_addr", wr_addr0, 3);

    // short frame: 12 bits of a write to addr 2
    s = stb0; e = err0;
    frame(0, 32'h825, 12, 100, rd);
    chk("short_regs", regs0, 64'h0000_0000_A500_0000);
    chk("short_errs", err0 - e, 1);

    // over-length frame: write addr 2 = 0x55 plus one extra bit
    frame(0, 32'h104AB, 17, 100, rd);
    chk("long_regs", regs0, 64'h0000_0000_A500_0000);
    chk("long_errs", err0 - e, 2);
    chk("bad_strobes", stb0 - s, 0);

    // read of out-of-range addr 9
    e = err0;
    frame(0, 32'h0900, 16, 100, rd);
    chk("rd9_data", rd[15:0], 16'h0000);
    chk("rd9_errs", err0 - e, 1);

    // back-to-back writes with a 4-cycle cs_n gap
    s = stb0; e = err0;
    frame(0, 32'h8011, 16, 40, rd);
    frame(0, 32'h87EE, 16, 100, rd);
    chk("b2b_regs", regs0, 64'hEE00_0000_A500_0011);
    chk("b2b_strobes", stb0 - s, 2);
    chk("b2b_wr_addr", wr_addr0, 7);
    chk("b2b_errs", err0 - e, 0);

    // reset in the middle of a write to addr 1
    cs_low(0);
    spi_bits(0, 32'h81, 8, rd);
    rst_n = 1'b0;
    #20;
    chk("mid_rst_regs", regs0, 0);
    chk("mid_rst_wr_addr", wr_addr0, 0);
    #10 rst_n = 1'b1;
    #20;
    chk("post_rst_sdo", sdo0, 0);
    chk("post_rst_frame_err", frame_err0, 0);
    s = stb0; e = err0;
    spi_bits(0, 32'h33, 8, rd);
    cs_high(0, 100);
    chk("aborted_regs", regs0, 0);
    chk("aborted_strobes", stb0 - s, 0);
    chk("aborted_errs", err0 - e, 0);
    frame(0, 32'h8133, 16, 100, rd);
    chk("after_rst_regs", regs0, 64'h0000_0000_0000_3300);
    chk("after_rst_wr_addr", wr_addr0, 1);
    chk("after_rst_strobes", stb0 - s, 1);

    // wide build: write/read 0xBEEF at addr 4
    s = stb1; e = err1;
    frame(1, 32'hCBEEF, 20, 100, rd);
    chk("p_wr_reg4", regs1[79:64], 16'hBEEF);
    chk("p_other_regs", regs1[63:0], 0);
    chk("p_wr_addr", wr_addr1, 4);
    chk("p_strobes", stb1 - s, 1);
    frame(1, 32'h40000, 20, 100, rd);
    chk("p_rd_data", rd[19:0], 20'h0BEEF);
    chk("p_errs", err1 - e, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
